// File: rtl/fft_pkg.sv
// fft_pkg: shared sample type, defaults and bit-reversal helper
// for the FFT output path.
package fft_pkg;

  localparam int LOG2N_DEF = 5;
  localparam int DW_DEF    = 16;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  // Reverse the low `bits` bits of value; bits above are returned as 0.
  function automatic logic [7:0] bitrev(
    input logic [7:0] value,
    input int         bits
  );
    logic [7:0] r;
    logic [7:0] v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      if (i < bits) begin
        r = {r[6:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_if.sv
// fft_reorder_if: input and output valid/ready sample streams
// of the bit-reversal reorder buffer.
interface fft_reorder_if #(
  parameter int LOG2N = 5,
  parameter int DW    = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    in_r;
  logic signed [DW-1:0]    in_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DW-1:0]    out_r;
  logic signed [DW-1:0]    out_i;
  logic [LOG2N-1:0]        out_index;
  logic                    out_last;

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i,
    output out_index, out_last
  );

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i,
    input  out_index, out_last
  );

endinterface

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: N-entry sample register file, one write port
// and one combinational read port.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int  LOG2N = LOG2N_DEF,
  parameter type T     = cplx_t
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  T                 wdata,
  input  logic [LOG2N-1:0] raddr,
  output T                 rdata
);

  localparam int N = 1 << LOG2N;

  T mem [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong bit-reversal reorder buffer, takes FFT
// output in butterfly order and streams it in natural order.
module fft_reorder
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bitrev_en,
  fft_reorder_if.slave bus
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } sample_t;

  logic [1:0]       full;
  logic [1:0]       full_nx;
  logic [1:0]       mode;
  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_ptr;
  logic [LOG2N-1:0] rd_ptr;
  logic [LOG2N-1:0] waddr;
  logic             accept;
  logic             xfer;
  logic             wr_done;
  logic             rd_done;
  logic             mode_now;
  sample_t          wdata;
  sample_t          rdata [2];
  sample_t          cur;

  assign bus.in_ready = !full[wr_bank];
  assign accept  = bus.in_valid && bus.in_ready && !clr;
  assign xfer    = bus.out_valid && bus.out_ready && !clr;
  assign wr_done = accept && (wr_ptr == LAST);
  assign rd_done = xfer && (rd_ptr == LAST);

  // First sample of a frame already uses the freshly sampled mode.
  assign mode_now = (wr_ptr == '0) ? bitrev_en : mode[wr_bank];
  assign waddr = mode_now
               ? LOG2N'(bitrev(8'(wr_ptr), LOG2N))
               : wr_ptr;
  assign wdata = '{re: bus.in_r, im: bus.in_i};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .LOG2N (LOG2N),
      .T     (sample_t)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (accept && (wr_bank == 1'(b))),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata[b])
    );
  end

  assign cur           = rdata[rd_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_r     = cur.re;
  assign bus.out_i     = cur.im;
  assign bus.out_index = rd_ptr;
  assign bus.out_last  = full[rd_bank] && (rd_ptr == LAST);

  // Write and read completions always hit opposite banks.
  always_comb begin
    full_nx = full;
    if (wr_done) full_nx[wr_bank] = 1'b1;
    if (rd_done) full_nx[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= '0;
      mode    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else if (clr) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + LOG2N'(1);
        if (wr_ptr == '0) mode[wr_bank] <= bitrev_en;
        if (wr_done) wr_bank <= !wr_bank;
      end
      if (xfer) begin
        rd_ptr <= rd_ptr + LOG2N'(1);
        if (rd_done) rd_bank <= !rd_bank;
      end
      full <= full_nx;
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: directed bench for the bit-reversal reorder
// buffer with a frame-level reference queue.
module tb_fft_reorder;

  localparam int LOG2N = 5;
  localparam int N     = 32;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic bitrev_en = 1'b0;

  fft_reorder_if #(.LOG2N(LOG2N), .DW(DW)) bus ();

  fft_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bitrev_en (bitrev_en),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  logic signed [DW-1:0] exp_r [$];
  logic signed [DW-1:0] exp_i [$];
  int                   exp_idx [$];
  logic signed [DW-1:0] fr_r [N];
  logic signed [DW-1:0] fr_i [N];
  int   wp = 0;
  logic fmode = 1'b0;
  int   drops = 0;

  function automatic int rev5(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic model_accept(
    input logic signed [DW-1:0] r,
    input logic signed [DW-1:0] i
  );
    if (wp == 0) fmode = bitrev_en;
    fr_r[wp] = r;
    fr_i[wp] = i;
    wp++;
    if (wp == N) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = fmode ? rev5(j) : j;
        exp_r.push_back(fr_r[s]);
        exp_i.push_back(fr_i[s]);
        exp_idx.push_back(j);
      end
      wp = 0;
    end
  endtask

  task automatic send(
    input logic signed [DW-1:0] r,
    input logic signed [DW-1:0] i
  );
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_r = r;
    bus.in_i = i;
    if (!bus.in_ready) drops++;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      model_accept(r, i);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((exp_r.size() != 0 || bus.out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(exp_r.size()), 32'd0);
  endtask

  int cyc = 0;
  int first = -1;
  int last = -1;
  int vcnt = 0;

  always @(negedge clk) begin
    if (rst && !clr && bus.out_valid && bus.out_ready) begin
      if (exp_r.size() == 0) begin
        check("unexpected_out", 32'(bus.out_valid), 32'd0);
      end else begin
        int idx;
        idx = exp_idx.pop_front();
        check("out_r", 32'(bus.out_r), 32'(exp_r.pop_front()));
        check("out_i", 32'(bus.out_i), 32'(exp_i.pop_front()));
        check("out_index", 32'(bus.out_index), 32'(idx));
        check("out_last", 32'(bus.out_last), 32'(idx == N - 1));
      end
    end
    cyc++;
    if (bus.out_valid) begin
      if (first < 0) first = cyc;
      last = cyc;
      vcnt++;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_r", 32'(bus.out_r), 32'd0);
    check("rst_out_i", 32'(bus.out_i), 32'd0);
    check("rst_out_index", 32'(bus.out_index), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single bit-reversed frame, k -> (k, -k)
    bitrev_en = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      send(16'(k), -16'(k));
      if (k == N - 2) check("early_valid", 32'(bus.out_valid), 32'd0);
    end
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_index", 32'(bus.out_index), 32'd0);
    check("lat_bin0", 32'(bus.out_r), 32'd0);
    drain();

    // three frames back to back
    drops = 0;
    vcnt = 0;
    first = -1;
    for (int k = 0; k < 3 * N; k++) send(16'(k * 3), 16'(k + 100));
    drain();
    check("stream_drops", 32'(drops), 32'd0);
    check("stream_vcnt", 32'(vcnt), 32'd96);
    check("stream_span", 32'(last - first + 1), 32'd96);

    // backpressure: both banks fill
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2 * N; k++) send(16'(k + 7), 16'(k - 9));
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_r = 16'h5555;
    bus.in_i = 16'h5555;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_hold", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (N - 1) @(posedge clk);
    #1;
    check("bp_last", 32'(bus.out_last), 32'd1);
    check("bp_still_full", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_release", 32'(bus.in_ready), 32'd1);
    check("bp_next_idx", 32'(bus.out_index), 32'd0);
    drain();

    // mode latched per frame
    bitrev_en = 1'b1;
    for (int k = 0; k < N; k++) send(16'(k + 200), 16'(k));
    bitrev_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 16) bitrev_en = 1'b1;
      send(16'(k), 16'(k));
    end
    drain();

    // clr after 10 accepts
    for (int k = 0; k < 10; k++) send(16'(999), 16'(k));
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    wp = 0;
    check("clr_out_valid", 32'(bus.out_valid), 32'd0);
    check("clr_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < N; k++) send(16'(k + 50), 16'(-k));
    drain();

    // async reset after 10 accepts
    for (int k = 0; k < 10; k++) send(16'(777), 16'(k));
    #2;
    rst = 1'b0;
    #1;
    wp = 0;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bitrev_en = 1'b1;
    for (int k = 0; k < N; k++) send(16'(k * 5), 16'(k + 1));
    drain();

    // full-scale boundary values
    bitrev_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k % 2 == 0) send(16'sh7FFF, 16'sh8000);
      else send(16'sh8000, 16'sh7FFF);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Parametrised bit-reversal reorder buffer for the FFT output path. It accepts one complex sample per cycle in bit-reversed (butterfly-output) order and streams it out in natural order. Two ping-pong banks allow sustained one-sample-per-cycle throughput. It sits between the last butterfly stage and the downstream consumer, with valid/ready handshakes on both sides.

## Interface
- LOG2N, 5: log2 of FFT points; N = 2**LOG2N; legal range 2..8.
- DW, 16: signed width of each real and imaginary component.
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush of all pointers and flags; storage contents are kept.
- bitrev_en  in  1  1 = write address is bitrev(k); 0 = natural pass-through. Sampled per frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  the buffer can accept a sample.
- in_r, in_i  in  DW  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  the consumer accepts the sample.
- out_r, out_i  out  DW  signed output sample.
- out_index  out  LOG2N  natural-order bin index of the current output.
- out_last  out  1  high on the final bin (index N-1) of a frame.

## Operation
- Storage is 2 banks of N complex entries each. Per-bank state: `full[b]` and `mode[b]`.
- Write side state: `wr_bank` and `wr_ptr` (LOG2N bits).
  - in_ready = !full[wr_bank].
  - An accept occurs on in_valid & in_ready. The sample is written to bank[wr_bank] at address A, where A = mode ? bitrev(wr_ptr) : wr_ptr; then wr_ptr increments.
  - When wr_ptr == 0 on an accept, bitrev_en is latched into mode[wr_bank]. That same sample uses the newly latched value.
  - An accept with wr_ptr == N-1 sets full[wr_bank], toggles wr_bank and wraps wr_ptr to 0.
- Read side state: `rd_bank` and `rd_ptr`.
  - out_valid = full[rd_bank].
  - out_r/out_i = bank[rd_bank][rd_ptr]; out_index = rd_ptr; out_last = out_valid & (rd_ptr == N-1).
  - A transfer occurs on out_valid & out_ready; rd_ptr then increments.
  - A transfer at rd_ptr == N-1 clears full[rd_bank], toggles rd_bank and wraps rd_ptr to 0.
- Simultaneous write-complete and read-complete always target different banks, so both take effect in the same cycle.
- in_valid with in_ready low is ignored; no sample is lost. Holding the input stable is the upstream's responsibility.
- out_r, out_i and out_index stay stable while out_valid & !out_ready.
- clr: pointers → 0, banks → 0, full → 0. clr takes priority over any accept or transfer in the same cycle.
- The reset value of every output is 0, except in_ready, which is 1. Storage and mode bits also reset to 0.

## Timing
- Write latency is 1 cycle: the entry is visible to the read side on the following cycle.
- Frame latency: out_valid rises the cycle after the Nth accept of a frame. Bin 0 is presented that cycle.
- Throughput: with out_ready held at 1 and in_valid held at 1, in_ready never drops. The Nth read of bank A coincides with the Nth write of bank B.
- Backpressure: once both banks are full, in_ready = 0. in_ready returns to 1 the cycle after the transfer of out_last.
- Reset mid-frame: all partial frame data is discarded and in_ready = 1 immediately.

## Structure
- Shared `fft_pkg` holds:
  - `bitrev(value, bits)` function;
  - `cplx_t` struct {real, imag} parametrised by DW default 16;
  - LOG2N default constant.
- Sub-module `fft_reorder_bank`: N×cplx_t register file with one write port (we, waddr, wdata) and one combinational read port, reset to 0. It is instantiated twice.
- The top level holds only the pointers, flags and mode latches, plus the output mux.

## Test plan
- LOG2N=5, bitrev_en=1, out_ready=1, input k has in_r=k, in_i=-k for k=0..31:
  - outputs appear in order j=0..31 with out_r=bitrev5(j), e.g. j=1→16, j=3→24, j=31→31;
  - out_i = -out_r; out_last only at j=31.
- Back-to-back streaming of 3 frames with in_valid=1 and out_ready=1:
  - in_ready stays 1 throughout;
  - out_valid is continuous from cycle 33 through cycle 128.
- out_ready=0 while 64 samples are offered:
  - in_ready falls after accept 64;
  - after one out_ready pulse on out_last, in_ready returns to 1 on the next cycle.
- Frame 1 with bitrev_en=1, then frame 2 with bitrev_en=0 (bitrev_en toggled mid-frame 2):
  - frame 2 outputs out_r = index, i.e. natural order is kept.
- Assert rst or clr after 10 accepts:
  - out_valid=0, in_ready=1;
  - the next 32 accepts form a clean frame.
- Boundary samples 0x7FFF and 0x8000 on both components come out unmodified.
